// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and response helpers for the block-RAM slave.
package axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    // Encoding order already ranks severity: DECERR > SLVERR > OKAY.
    function automatic resp_e worst_resp(input resp_e a, input resp_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_burst_addr.sv
// Per-beat AXI4 burst address generator: FIXED/INCR/WRAP stepping, beat
// counting and burst-legality checks latched at address acceptance.
module axi4_burst_addr
    import axi4_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        beat,
    output logic              last,
    output logic              err,
    output logic              size_err
);
    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] inc_q, inc_d;
    logic [ADDR_W-1:0] wrap_mask_q, wrap_mask_d;
    logic [7:0]        beat_q, beat_d;
    logic [7:0]        len_q, len_d;
    burst_e            burst_q, burst_d;
    logic              err_q, err_d;
    logic              size_err_q, size_err_d;
    logic [ADDR_W-1:0] addr_incr;

    always_comb begin
        addr_d      = addr_q;
        inc_d       = inc_q;
        wrap_mask_d = wrap_mask_q;
        beat_d      = beat_q;
        len_d       = len_q;
        burst_d     = burst_q;
        err_d       = err_q;
        size_err_d  = size_err_q;
        addr_incr   = addr_q + inc_q;
        if (load) begin
            addr_d      = start_addr;
            inc_d       = ADDR_W'(1) << size;
            wrap_mask_d = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
            beat_d      = '0;
            len_d       = len;
            size_err_d  = (size > 3'(OFF_W));
            err_d       = 1'b0;
            case (burst_e'(burst))
                BURST_FIXED: burst_d = BURST_FIXED;
                BURST_INCR:  burst_d = BURST_INCR;
                BURST_WRAP: begin
                    // Illegal wrap lengths are flagged and stepped as INCR.
                    if (len inside {8'd1, 8'd3, 8'd7, 8'd15}) begin
                        burst_d = BURST_WRAP;
                    end else begin
                        burst_d = BURST_INCR;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    burst_d = BURST_INCR;
                    err_d   = 1'b1;
                end
            endcase
            err_d = err_d | size_err_d;
        end else if (step) begin
            beat_d = beat_q + 8'd1;
            case (burst_q)
                BURST_FIXED: addr_d = addr_q;
                BURST_WRAP:  addr_d = (addr_q & ~wrap_mask_q) | (addr_incr & wrap_mask_q);
                default:     addr_d = addr_incr;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q      <= '0;
            inc_q       <= '0;
            wrap_mask_q <= '0;
            beat_q      <= '0;
            len_q       <= '0;
            burst_q     <= BURST_FIXED;
            err_q       <= 1'b0;
            size_err_q  <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            inc_q       <= inc_d;
            wrap_mask_q <= wrap_mask_d;
            beat_q      <= beat_d;
            len_q       <= len_d;
            burst_q     <= burst_d;
            err_q       <= err_d;
            size_err_q  <= size_err_d;
        end
    end

    assign addr     = addr_q;
    assign beat     = beat_q;
    assign last     = (beat_q == len_q);
    assign err      = err_q;
    assign size_err = size_err_q;

endmodule

// File: rtl/axi4_sram_mem.sv
// AXI4 slave backed by an inferred simple dual-port block RAM, with
// independent read and write burst engines and per-beat error responses.
module axi4_sram_mem
    import axi4_pkg::*;
#(
    parameter int unsigned       DATA_W     = 64,
    parameter int unsigned       ID_W       = 4,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0] ADDR_MASK  = 32'h07ff_ffff
) (
    input  logic                clock,
    input  logic                reset,
    output logic                io_axi4_0_aw_ready,
    input  logic                io_axi4_0_aw_valid,
    input  logic [ID_W-1:0]     io_axi4_0_aw_id,
    input  logic [ADDR_W-1:0]   io_axi4_0_aw_addr,
    input  logic [7:0]          io_axi4_0_aw_len,
    input  logic [2:0]          io_axi4_0_aw_size,
    input  logic [1:0]          io_axi4_0_aw_burst,
    input  logic                io_axi4_0_aw_lock,
    input  logic [3:0]          io_axi4_0_aw_cache,
    input  logic [2:0]          io_axi4_0_aw_prot,
    input  logic [3:0]          io_axi4_0_aw_qos,
    output logic                io_axi4_0_w_ready,
    input  logic                io_axi4_0_w_valid,
    input  logic [DATA_W-1:0]   io_axi4_0_w_data,
    input  logic [DATA_W/8-1:0] io_axi4_0_w_strb,
    input  logic                io_axi4_0_w_last,
    input  logic                io_axi4_0_b_ready,
    output logic                io_axi4_0_b_valid,
    output logic [ID_W-1:0]     io_axi4_0_b_id,
    output logic [1:0]          io_axi4_0_b_resp,
    output logic                io_axi4_0_ar_ready,
    input  logic                io_axi4_0_ar_valid,
    input  logic [ID_W-1:0]     io_axi4_0_ar_id,
    input  logic [ADDR_W-1:0]   io_axi4_0_ar_addr,
    input  logic [7:0]          io_axi4_0_ar_len,
    input  logic [2:0]          io_axi4_0_ar_size,
    input  logic [1:0]          io_axi4_0_ar_burst,
    input  logic                io_axi4_0_ar_lock,
    input  logic [3:0]          io_axi4_0_ar_cache,
    input  logic [2:0]          io_axi4_0_ar_prot,
    input  logic [3:0]          io_axi4_0_ar_qos,
    input  logic                io_axi4_0_r_ready,
    output logic                io_axi4_0_r_valid,
    output logic [ID_W-1:0]     io_axi4_0_r_id,
    output logic [DATA_W-1:0]   io_axi4_0_r_data,
    output logic [1:0]          io_axi4_0_r_resp,
    output logic                io_axi4_0_r_last
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_BURST} rstate_e;

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------- write engine ----------------
    wstate_e           wstate_q, wstate_d;
    logic [ID_W-1:0]   wid_q, wid_d;
    resp_e             wresp_q, wresp_d, wr_beat_resp;
    logic              aw_hs, w_hs, b_hs, wr_en, wr_in_range;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_beat;
    logic              wr_last, wr_err, wr_size_err;

    assign aw_hs = io_axi4_0_aw_valid && io_axi4_0_aw_ready;
    assign w_hs  = io_axi4_0_w_valid && io_axi4_0_w_ready;
    assign b_hs  = io_axi4_0_b_valid && io_axi4_0_b_ready;

    axi4_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_addr (
        .clock      (clock),
        .reset      (reset),
        .load       (aw_hs),
        .start_addr (io_axi4_0_aw_addr & ADDR_MASK),
        .len        (io_axi4_0_aw_len),
        .size       (io_axi4_0_aw_size),
        .burst      (io_axi4_0_aw_burst),
        .step       (w_hs),
        .addr       (wr_addr),
        .beat       (wr_beat),
        .last       (wr_last),
        .err        (wr_err),
        .size_err   (wr_size_err)
    );

    always_ff @(posedge clock) begin
        if (reset) wstate_q <= W_IDLE;
        else       wstate_q <= wstate_d;
    end

    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE:  if (aw_hs) wstate_d = W_DATA;
            W_DATA:  if (w_hs && wr_last) wstate_d = W_RESP;
            W_RESP:  if (b_hs) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        io_axi4_0_aw_ready = 1'b0;
        io_axi4_0_w_ready  = 1'b0;
        io_axi4_0_b_valid  = 1'b0;
        if (!reset) begin
            case (wstate_q)
                W_IDLE:  io_axi4_0_aw_ready = 1'b1;
                W_DATA:  io_axi4_0_w_ready  = 1'b1;
                W_RESP:  io_axi4_0_b_valid  = 1'b1;
                default: ;
            endcase
        end
    end

    assign wr_in_range = ~|wr_addr[ADDR_W-1:OFF_W+DEPTH_LOG2];
    assign wr_en       = w_hs && wr_in_range && !wr_size_err;

    always_comb begin
        wr_beat_resp = RESP_OKAY;
        if (wr_err || (io_axi4_0_w_last != wr_last)) wr_beat_resp = RESP_SLVERR;
        if (!wr_in_range) wr_beat_resp = RESP_DECERR;
        wid_d   = wid_q;
        wresp_d = wresp_q;
        if (aw_hs) begin
            wid_d   = io_axi4_0_aw_id;
            wresp_d = RESP_OKAY;
        end else if (w_hs) begin
            wresp_d = worst_resp(wresp_q, wr_beat_resp);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wid_q   <= '0;
            wresp_q <= RESP_OKAY;
        end else begin
            wid_q   <= wid_d;
            wresp_q <= wresp_d;
        end
    end

    assign io_axi4_0_b_id   = wid_q;
    assign io_axi4_0_b_resp = wresp_q;

    // ---------------- read engine ----------------
    rstate_e           rstate_q, rstate_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    resp_e             r_resp_q, r_resp_d, rd_beat_resp;
    logic              r_valid_q, r_valid_d, r_last_q, r_last_d, r_zero_q, r_zero_d;
    logic              rd_pend_q, rd_pend_d;
    logic              ar_hs, r_hs, rd_issue, rd_in_range;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_beat;
    logic              rd_last, rd_err, rd_size_err;
    logic [DATA_W-1:0] ram_rdata_q;

    assign ar_hs    = io_axi4_0_ar_valid && io_axi4_0_ar_ready;
    assign r_hs     = io_axi4_0_r_valid && io_axi4_0_r_ready;
    // The RAM output register doubles as the R holding register, so a read
    // may only issue when the current beat is absent or leaving this cycle.
    assign rd_issue = rd_pend_q && (!r_valid_q || io_axi4_0_r_ready);

    axi4_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_addr (
        .clock      (clock),
        .reset      (reset),
        .load       (ar_hs),
        .start_addr (io_axi4_0_ar_addr & ADDR_MASK),
        .len        (io_axi4_0_ar_len),
        .size       (io_axi4_0_ar_size),
        .burst      (io_axi4_0_ar_burst),
        .step       (rd_issue),
        .addr       (rd_addr),
        .beat       (rd_beat),
        .last       (rd_last),
        .err        (rd_err),
        .size_err   (rd_size_err)
    );

    always_ff @(posedge clock) begin
        if (reset) rstate_q <= R_IDLE;
        else       rstate_q <= rstate_d;
    end

    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (ar_hs) rstate_d = R_BURST;
            R_BURST: if (r_hs && r_last_q) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        io_axi4_0_ar_ready = !reset && (rstate_q == R_IDLE);
    end

    assign rd_in_range = ~|rd_addr[ADDR_W-1:OFF_W+DEPTH_LOG2];

    always_comb begin
        rd_beat_resp = RESP_OKAY;
        if (rd_err) rd_beat_resp = RESP_SLVERR;
        if (!rd_in_range) rd_beat_resp = RESP_DECERR;
        r_valid_d = r_valid_q;
        r_last_d  = r_last_q;
        r_resp_d  = r_resp_q;
        r_zero_d  = r_zero_q;
        r_id_d    = r_id_q;
        rd_pend_d = rd_pend_q;
        if (ar_hs) begin
            r_id_d    = io_axi4_0_ar_id;
            rd_pend_d = 1'b1;
        end
        if (rd_issue) begin
            r_valid_d = 1'b1;
            r_last_d  = rd_last;
            r_resp_d  = rd_beat_resp;
            r_zero_d  = !rd_in_range || rd_size_err;
            if (rd_last) rd_pend_d = 1'b0;
        end else if (io_axi4_0_r_ready) begin
            r_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            r_resp_q  <= RESP_OKAY;
            r_zero_q  <= 1'b0;
            r_id_q    <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            r_valid_q <= r_valid_d;
            r_last_q  <= r_last_d;
            r_resp_q  <= r_resp_d;
            r_zero_q  <= r_zero_d;
            r_id_q    <= r_id_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign io_axi4_0_r_valid = r_valid_q && !reset;
    assign io_axi4_0_r_last  = r_last_q;
    assign io_axi4_0_r_resp  = r_resp_q;
    assign io_axi4_0_r_id    = r_id_q;
    assign io_axi4_0_r_data  = r_zero_q ? '0 : ram_rdata_q;

    // ---------------- RAM (read-first, byte enables) ----------------
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (io_axi4_0_w_strb[i]) begin
                    mem[wr_addr[OFF_W +: DEPTH_LOG2]][8*i +: 8] <= io_axi4_0_w_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rd_issue) ram_rdata_q <= mem[rd_addr[OFF_W +: DEPTH_LOG2]];
    end

    logic unused_inputs;
    assign unused_inputs = ^{io_axi4_0_aw_lock, io_axi4_0_aw_cache, io_axi4_0_aw_prot,
                             io_axi4_0_aw_qos, io_axi4_0_ar_lock, io_axi4_0_ar_cache,
                             io_axi4_0_ar_prot, io_axi4_0_ar_qos, wr_addr[OFF_W-1:0],
                             rd_addr[OFF_W-1:0], wr_beat, rd_beat};

endmodule
